trap_epc_sequencer: RTL and testbench



---
 rtl/trap_epc_sequencer.sv | 133 +++++++++++++
 tb/tb_trap_epc_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/trap_epc_sequencer.sv
// trap_epc_sequencer: captures the exception PC of the oldest valid pipeline
// stage on a trap, holds a flush window, then hands the EPC to the CSR file.
module trap_epc_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          C_EXT        = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_STAGES*XLEN-1:0] stage_pc_i,
  input  logic [NUM_STAGES-1:0]      stage_valid_i,
  input  logic                       trap_req_i,
  input  logic                       clear_i,
  output logic                       flush_o,
  output logic                       busy_o,
  output logic [XLEN-1:0]            mepc_o,
  output logic                       mepc_valid_o,
  input  logic                       mepc_ready_i,
  output logic [2:0]                 sel_idx_o,
  output logic                       no_valid_o
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned LAST_CNT = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CNT);
  // Compressed ISA keeps 2-byte alignment, base ISA forces 4-byte alignment.
  localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [2:0]        sel_q, sel_d;
  logic              no_valid_q, no_valid_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic              mepc_valid_q, mepc_valid_d;

  logic [2:0]        sel_idx_c;
  logic [XLEN-1:0]   sel_pc_c;
  logic              none_valid_c;

  // Oldest-stage picker: the highest valid index wins, stage 0 when none valid.
  always_comb begin
    sel_idx_c    = 3'd0;
    sel_pc_c     = stage_pc_i[XLEN-1:0];
    none_valid_c = ~|stage_valid_i;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (stage_valid_i[i]) begin
        sel_idx_c = 3'(i);
        sel_pc_c  = stage_pc_i[i*XLEN +: XLEN];
      end
    end
  end

  // Next-state, counter and capture logic; output flags follow the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mepc_d     = mepc_q;
    sel_d      = sel_q;
    no_valid_d = no_valid_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trap_req_i) begin
            mepc_d     = sel_pc_c & ALIGN_MASK;
            sel_d      = sel_idx_c;
            no_valid_d = none_valid_c;
            cnt_d      = '0;
            state_d    = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_COMMIT;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (mepc_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    flush_d      = (state_d == ST_DRAIN);
    busy_d       = (state_d != ST_IDLE);
    mepc_valid_d = (state_d == ST_COMMIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mepc_q       <= '0;
      sel_q        <= 3'd0;
      no_valid_q   <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      mepc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mepc_q       <= mepc_d;
      sel_q        <= sel_d;
      no_valid_q   <= no_valid_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      mepc_valid_q <= mepc_valid_d;
    end
  end

  assign flush_o      = flush_q;
  assign busy_o       = busy_q;
  assign mepc_o       = mepc_q;
  assign mepc_valid_o = mepc_valid_q;
  assign sel_idx_o    = sel_q;
  assign no_valid_o   = no_valid_q;

endmodule

// File: tb/tb_trap_epc_sequencer.sv
// Directed bench for trap_epc_sequencer: default build, a base-ISA alignment
// build sharing its inputs, and an 8-stage build with no drain window.
module tb_trap_epc_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] stage_pc;
  logic [4:0]   stage_valid;
  logic         trap_req;
  logic         clear;
  logic         mepc_ready;

  logic         flush, busy, mepc_valid, no_valid;
  logic [31:0]  mepc;
  logic [2:0]   sel_idx;

  logic         c0_flush, c0_busy, c0_mepc_valid, c0_no_valid;
  logic [31:0]  c0_mepc;
  logic [2:0]   c0_sel_idx;

  logic [255:0] pc8;
  logic [7:0]   valid8;
  logic         trap8, ready8;
  logic         d0_flush, d0_busy, d0_mepc_valid, d0_no_valid;
  logic [31:0]  d0_mepc;
  logic [2:0]   d0_sel_idx;
  logic         d0_flush_seen;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_epc_sequencer #(.XLEN(32), .NUM_STAGES(5), .DRAIN_CYCLES(3), .C_EXT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .stage_pc_i(stage_pc), .stage_valid_i(stage_valid),
    .trap_req_i(trap_req), .clear_i(clear), .flush_o(flush), .busy_o(busy),
    .mepc_o(mepc), .mepc_valid_o(mepc_valid), .mepc_ready_i(mepc_ready),
    .sel_idx_o(sel_idx), .no_valid_o(no_valid));

  trap_epc_sequencer #(.XLEN(32), .NUM_STAGES(5), .DRAIN_CYCLES(3), .C_EXT(1'b0)) u_dut_c0 (
    .clk(clk), .reset(reset), .stage_pc_i(stage_pc), .stage_valid_i(stage_valid),
    .trap_req_i(trap_req), .clear_i(clear), .flush_o(c0_flush), .busy_o(c0_busy),
    .mepc_o(c0_mepc), .mepc_valid_o(c0_mepc_valid), .mepc_ready_i(mepc_ready),
    .sel_idx_o(c0_sel_idx), .no_valid_o(c0_no_valid));

  trap_epc_sequencer #(.XLEN(32), .NUM_STAGES(8), .DRAIN_CYCLES(0), .C_EXT(1'b1)) u_dut_d0 (
    .clk(clk), .reset(reset), .stage_pc_i(pc8), .stage_valid_i(valid8),
    .trap_req_i(trap8), .clear_i(clear), .flush_o(d0_flush), .busy_o(d0_busy),
    .mepc_o(d0_mepc), .mepc_valid_o(d0_mepc_valid), .mepc_ready_i(ready8),
    .sel_idx_o(d0_sel_idx), .no_valid_o(d0_no_valid));

  // Sticky record of any flush from the no-drain build outside reset.
  always @(negedge clk) begin
    if (!reset && d0_flush) d0_flush_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pcs(input logic [31:0] base);
    for (int i = 0; i < 5; i++) stage_pc[i*32 +: 32] = base + 32'(4 * i);
  endtask

  initial begin
    d0_flush_seen = 1'b0;
    reset = 1'b1; clear = 1'b0; trap_req = 1'b0; mepc_ready = 1'b0;
    stage_pc = '0; stage_valid = '0;
    pc8 = '0; valid8 = '0; trap8 = 1'b0; ready8 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mepc", 64'(mepc), 64'd0);
    check("rst_valid", 64'(mepc_valid), 64'd0);
    check("rst_sel", 64'(sel_idx), 64'd0);
    check("rst_novalid", 64'(no_valid), 64'd0);

    // 1: all stages valid, oldest stage 4 wins, 3 drain cycles, valid at T+4
    set_pcs(32'h100); stage_valid = 5'b11111;
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    check("t1_sel", 64'(sel_idx), 64'd4);
    check("t1_mepc", 64'(mepc), 64'h110);
    check("t1_c0_mepc", 64'(c0_mepc), 64'h110);
    check("t1_flush0", 64'(flush), 64'd1);
    check("t1_valid0", 64'(mepc_valid), 64'd0);
    tick();
    check("t1_flush1", 64'(flush), 64'd1);
    tick();
    check("t1_flush2", 64'(flush), 64'd1);
    check("t1_valid2", 64'(mepc_valid), 64'd0);
    tick();
    check("t1_flush3", 64'(flush), 64'd0);
    check("t1_valid3", 64'(mepc_valid), 64'd1);
    check("t1_busy3", 64'(busy), 64'd1);
    mepc_ready = 1'b1; tick();
    check("t1_done_valid", 64'(mepc_valid), 64'd0);
    check("t1_done_busy", 64'(busy), 64'd0);
    check("t1_keep_mepc", 64'(mepc), 64'h110);

    // 2: stages 1 and 2 valid, misaligned PC at stage 2
    stage_pc = {32'h500, 32'h400, 32'h203, 32'h1FE, 32'h0F0};
    stage_valid = 5'b00110;
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    check("t2_sel", 64'(sel_idx), 64'd2);
    check("t2_mepc_c1", 64'(mepc), 64'h202);
    check("t2_mepc_c0", 64'(c0_mepc), 64'h200);
    check("t2_novalid", 64'(no_valid), 64'd0);
    repeat (4) tick();
    check("t2_idle", 64'(busy), 64'd0);

    // 3: nothing valid, stage 0 PC used
    stage_pc = {32'h999, 32'h888, 32'h777, 32'h666, 32'h80};
    stage_valid = 5'b00000;
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    check("t3_novalid", 64'(no_valid), 64'd1);
    check("t3_sel", 64'(sel_idx), 64'd0);
    check("t3_mepc", 64'(mepc), 64'h80);
    repeat (4) tick();
    check("t3_idle", 64'(busy), 64'd0);

    // 4: backpressure in COMMIT with noisy inputs
    mepc_ready = 1'b0;
    set_pcs(32'h300); stage_valid = 5'b11111;
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    tick(); tick(); tick();
    check("t4_commit_valid", 64'(mepc_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      trap_req = ~trap_req;
      set_pcs(32'h700 + 32'(k * 32));
      stage_valid = 5'(k + 1);
      tick();
      check("t4_hold_valid", 64'(mepc_valid), 64'd1);
      check("t4_hold_mepc", 64'(mepc), 64'h310);
    end
    trap_req = 1'b0; mepc_ready = 1'b1; tick();
    check("t4_xfer_valid", 64'(mepc_valid), 64'd0);
    check("t4_xfer_busy", 64'(busy), 64'd0);
    tick();
    check("t4_single_xfer", 64'(mepc_valid), 64'd0);
    check("t4_sel_kept", 64'(sel_idx), 64'd4);

    // 5: clear during second drain cycle
    set_pcs(32'h600); stage_valid = 5'b01111;
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    check("t5_capture", 64'(mepc), 64'h60C);
    tick();
    check("t5_drain2", 64'(flush), 64'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t5_clr_flush", 64'(flush), 64'd0);
    check("t5_clr_busy", 64'(busy), 64'd0);
    check("t5_clr_valid", 64'(mepc_valid), 64'd0);
    check("t5_clr_mepc", 64'(mepc), 64'h60C);
    tick(); tick(); tick();
    check("t5_no_valid_later", 64'(mepc_valid), 64'd0);

    // 6: eight stages, no drain window
    for (int i = 0; i < 8; i++) pc8[i*32 +: 32] = 32'h1000 + 32'(4 * i);
    valid8 = 8'hFF;
    trap8 = 1'b1; tick(); trap8 = 1'b0;
    check("t6_valid_t1", 64'(d0_mepc_valid), 64'd1);
    check("t6_sel", 64'(d0_sel_idx), 64'd7);
    check("t6_mepc", 64'(d0_mepc), 64'h101C);
    check("t6_flush", 64'(d0_flush), 64'd0);
    ready8 = 1'b1; tick();
    check("t6_idle", 64'(d0_busy), 64'd0);
    check("t6_flush_never", 64'(d0_flush_seen), 64'd0);

    // 5b: reset together with clear wipes everything
    trap_req = 1'b1; tick(); trap_req = 1'b0;
    reset = 1'b1; clear = 1'b1; tick(); reset = 1'b0; clear = 1'b0;
    check("t5b_flush", 64'(flush), 64'd0);
    check("t5b_busy", 64'(busy), 64'd0);
    check("t5b_mepc", 64'(mepc), 64'd0);
    check("t5b_valid", 64'(mepc_valid), 64'd0);
    check("t5b_sel", 64'(sel_idx), 64'd0);
    check("t5b_novalid", 64'(no_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
